// File: rtl/data_memory_unit_pkg.sv
// Shared definitions for the data memory unit: access-size encodings,
// FSM state type and the supported response-latency range.
package data_memory_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/data_memory_unit_mem_lane_align.sv
// Combinational byte-lane steering: store enables and replication,
// load lane extraction with sign/zero extension, and the alignment check.
module mem_lane_align
    import data_memory_unit_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_rep_o,
    output logic [31:0] load_data_o,
    output logic        align_err_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rword_i[8*addr_lo_i +: 8];
    assign lane_h = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        byte_en_o   = 4'b0000;
        wdata_rep_o = '0;
        load_data_o = '0;
        align_err_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                byte_en_o   = 4'b0001 << addr_lo_i;
                wdata_rep_o = {4{wdata_i[7:0]}};
                load_data_o = {{24{~unsigned_i & lane_b[7]}}, lane_b};
            end
            SZ_HALF: begin
                align_err_o = addr_lo_i[0];
                byte_en_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep_o = {2{wdata_i[15:0]}};
                load_data_o = {{16{~unsigned_i & lane_h[15]}}, lane_h};
            end
            SZ_WORD: begin
                align_err_o = (addr_lo_i != 2'b00);
                byte_en_o   = 4'b1111;
                wdata_rep_o = wdata_i;
                load_data_o = rword_i;
            end
            // reserved size encoding is rejected like a misaligned access
            default: align_err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory_unit.sv
// Single-port data memory with fixed-latency request/response handshake.
// state   | meaning
// IDLE    | ready; request accepted on req_valid
// WAIT    | counting down the remaining latency
// RESP    | resp_valid strobe, back to IDLE next edge
module data_memory_unit
    import data_memory_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [2:0] CNT_LOAD = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] result_q;
    logic              err_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;

    logic              accept;
    logic [IDX_W-1:0]  word_idx;
    logic              out_of_range;
    logic              align_err;
    logic              req_err;
    logic [3:0]        byte_en;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] load_res;

    assign word_idx     = req_addr[IDX_W+1:2];
    assign out_of_range = (req_addr >> (IDX_W + 2)) != '0;
    assign rd_word      = mem_q[word_idx];
    assign req_err      = out_of_range | align_err;
    assign accept       = req_valid & (state_q == ST_IDLE) & ~reset;
    assign load_res     = (req_write | req_err) ? '0 : load_data;

    mem_lane_align u_lane_align (
        .size_i      (req_size),
        .unsigned_i  (req_unsigned),
        .addr_lo_i   (req_addr[1:0]),
        .wdata_i     (req_wdata),
        .rword_i     (rd_word),
        .byte_en_o   (byte_en),
        .wdata_rep_o (wdata_rep),
        .load_data_o (load_data),
        .align_err_o (align_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            result_q     <= '0;
            err_q        <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                result_q <= load_res;
                err_q    <= req_err;
            end
            // with LATENCY=1 the response is loaded straight from the request path
            if (state_d == ST_RESP) begin
                if (state_q == ST_IDLE) begin
                    resp_rdata_q <= load_res;
                    resp_err_q   <= req_err;
                end else begin
                    resp_rdata_q <= result_q;
                    resp_err_q   <= err_q;
                end
            end
        end
    end

    // memory has no reset so preloaded contents survive a reset
    always_ff @(posedge clk) begin
        if (accept && req_write && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem_q[word_idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
            end
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 Parameter DATA_W, 32, data word width in bits; only 32 is supported.
REQ-002 Parameter DEPTH, 256, number of words; power of two, 4..65536.
REQ-003 Parameter ADDR_W, 32, byte-address width.
REQ-004 Parameter LATENCY, 2, accept-to-response cycles; legal range 1..7.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  unit can accept a request this cycle.
REQ-009 req_write  input  1  1 = store, 0 = load.
REQ-010 req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-011 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 req_addr  input  ADDR_W  byte address.
REQ-013 req_wdata  input  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-014 resp_valid  output  1  one-cycle response strobe.
REQ-015 resp_rdata  output  DATA_W  load result, extended; 0 for stores and errors.
REQ-016 resp_err  output  1  request rejected (misaligned, out of range, or illegal size).

Function
REQ-017 Storage SHALL be DEPTH x DATA_W words, little-endian: byte offset 0 maps to bits [7:0].
REQ-018 Word index SHALL be req_addr[log2(DEPTH)+1:2]; any set bit above that field SHALL be out of range.
REQ-019 Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=00; either SHALL set err.
REQ-020 FSM states SHALL be IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 Acceptance SHALL occur at a rising edge with req_valid=1 and req_ready=1; all request fields are captured at that edge.
REQ-022 A legal store SHALL update only the addressed byte lanes, at the acceptance edge.
REQ-023 A legal load SHALL read the word at the acceptance edge, then extract the selected lane and extend it into a registered result.
REQ-024 An erroneous request SHALL leave memory unchanged and SHALL return err=1 with rdata=0.
REQ-025 Acceptance with LATENCY=1 SHALL go directly to RESP; otherwise it SHALL go to WAIT with the counter loaded to LATENCY-2.
REQ-026 WAIT SHALL decrement the counter each cycle and SHALL move to RESP after the cycle in which the counter is 0.
REQ-027 resp_valid SHALL be high exactly one cycle: the cycle that starts LATENCY edges after acceptance.
REQ-028 RESP SHALL always return to IDLE on the next edge; maximum throughput is one request per LATENCY+1 cycles.
REQ-029 resp_rdata and resp_err SHALL hold their last values while resp_valid=0.
REQ-030 req_valid outside IDLE SHALL be ignored; the requester holds it until req_ready=1.

Reset
REQ-031 Reset SHALL take priority over acceptance, force IDLE, clear the counter, and drive req_ready=1, resp_valid=0, resp_rdata=0 and resp_err=0 from the next cycle.
REQ-032 Reset SHALL NOT clear memory contents; preload is done by file load into the memory array.
REQ-033 Reset during WAIT or RESP SHALL drop the pending response; a store accepted before reset remains committed.

Structure
REQ-034 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state type and the LATENCY bounds.
REQ-035 One sub-module, mem_lane_align, SHALL hold the combinational logic: byte-lane write-enable, write-data replication, load extraction and extension, and the alignment check.

Verification
REQ-036 Preload word0=0x800000FF; load byte addr 0 signed -> rdata 0xFFFFFFFF, err 0, resp_valid exactly 2 cycles after acceptance.
REQ-037 Same preload: load byte unsigned addr 0 -> 0x000000FF; load half signed addr 2 -> 0xFFFF8000.
REQ-038 Store half 0x1234 to addr 2, then load word addr 0 -> 0x123400FF.
REQ-039 Load word addr 1, and store word addr 4*DEPTH -> err 1, rdata 0, memory dump unchanged.
REQ-040 Assert reset in the WAIT cycle after a store of 5 to addr 8 -> no resp_valid, req_ready 1 next cycle, word2 reads 5.
REQ-041 Sweep LATENCY = 1, 2, 7 with req_valid held high -> resp_valid strobes every LATENCY+1 cycles.
